dcache_arbiter: RTL and testbench

DCACHE_ARBITER -- requirements
Module: dcache_arbiter

---
 rtl/dcache_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_dcache_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: arbitrates LSU loads and stores onto the data-cache
// controller, and services controller-reported misses by fetching a whole
// 128-byte block from next-level memory, writing it into the cache, and
// replaying the missed load if there was one.
// Optional build macro: DCACHE_ARB_PERF_EN adds read/write miss counters.
module dcache_arbiter (
    input  logic          clk,
    input  logic          rst,
    // load request / response
    input  logic          ld_req_valid,
    output logic          ld_req_ready,
    input  logic [31:0]   ld_addr,
    output logic          ld_resp_valid,
    output logic [31:0]   ld_resp_data,
    // store request
    input  logic          st_req_valid,
    output logic          st_req_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [3:0]    st_bmask,
    // cache controller read side
    output logic          ctl_raddr_valid,
    output logic [31:0]   ctl_raddr,
    input  logic          ctl_rdata_valid,
    input  logic [31:0]   ctl_rdata,
    // cache controller write / fill side
    output logic          ctl_waddr_valid,
    output logic [31:0]   ctl_waddr,
    output logic [1023:0] ctl_wdata,
    output logic [127:0]  ctl_wmask,
    input  logic          ctl_read_repair_request,
    input  logic          ctl_write_miss_repair,
    output logic          ctl_sent_repair,
    output logic          ctl_repair_resolved,
    // next-level memory
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [31:0]   mem_req_addr,
    input  logic          mem_resp_valid,
    input  logic [1023:0] mem_resp_data
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [31:0]   perf_ld_miss_cnt,
    output logic [31:0]   perf_st_miss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_REQ  = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_FILL     = 3'd3,
        S_RESOLVE  = 3'd4,
        S_REPLAY   = 3'd5
    } state_t;

    state_t          state_q;
    logic            ld_busy_q;      // one load in flight (hit or awaiting replay)
    logic [31:0]     ld_addr_q;      // address of the outstanding load
    logic [24:0]     shadow0_q;      // block of store issued 1 cycle ago (0 if none)
    logic [24:0]     shadow1_q;      // block of store issued 2 cycles ago (0 if none)
    logic [31:0]     blk_addr_q;     // block being repaired, offset forced to 0
    logic [1023:0]   blk_data_q;     // block returned by memory
    logic            replay_q;       // a read miss is pending replay after the fill

    logic            is_idle;
    logic            same_block;
    logic            ld_fire;
    logic            st_fire;
    logic            repair_any;

    assign is_idle    = (state_q == S_IDLE);
    assign same_block = st_req_valid && (st_addr[31:7] == ld_addr[31:7]);
    assign repair_any = ctl_read_repair_request || ctl_write_miss_repair;
    assign ld_fire    = ld_req_valid && ld_req_ready;
    assign st_fire    = st_req_valid && st_req_ready;

    // Handshake readiness; a same-block store takes priority over the load.
    always_comb begin
        ld_req_ready = 1'b0;
        st_req_ready = 1'b0;
        if (!rst && is_idle) begin
            st_req_ready = 1'b1;
            ld_req_ready = !ld_busy_q && !same_block;
        end
    end

    // Store-address shadow: a write miss names the store issued two cycles back.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow0_q <= '0;
            shadow1_q <= '0;
        end else begin
            shadow0_q <= st_fire ? st_addr[31:7] : '0;
            shadow1_q <= shadow0_q;
        end
    end

    // Outstanding-load tracking: set on issue, cleared when read data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_busy_q <= 1'b0;
            ld_addr_q <= '0;
        end else begin
            if (ld_fire) begin
                ld_busy_q <= 1'b1;
                ld_addr_q <= ld_addr;
            end else if (ctl_rdata_valid) begin
                ld_busy_q <= 1'b0;
            end
        end
    end

    // Miss-repair sequencer; a write miss wins when both misses are reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            blk_addr_q <= '0;
            blk_data_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (repair_any) begin
                        state_q    <= S_MEM_REQ;
                        blk_addr_q <= ctl_write_miss_repair ? {shadow1_q, 7'd0}
                                                            : {ld_addr_q[31:7], 7'd0};
                        replay_q   <= ctl_read_repair_request;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready) begin
                        state_q <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        blk_data_q <= mem_resp_data;
                        state_q    <= S_FILL;
                    end
                end
                S_FILL: begin
                    state_q <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    state_q <= replay_q ? S_REPLAY : S_IDLE;
                end
                S_REPLAY: begin
                    replay_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_ARB_PERF_EN
    logic [31:0] perf_ld_q;
    logic [31:0] perf_st_q;

    // Miss counters, bumped when a repair is accepted; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ld_q <= '0;
            perf_st_q <= '0;
        end else if (is_idle) begin
            if (ctl_read_repair_request) begin
                perf_ld_q <= perf_ld_q + 32'd1;
            end
            if (ctl_write_miss_repair) begin
                perf_st_q <= perf_st_q + 32'd1;
            end
        end
    end

    assign perf_ld_miss_cnt = perf_ld_q;
    assign perf_st_miss_cnt = perf_st_q;
`endif

    // Controller and memory outputs; everything is held at 0 while in reset.
    always_comb begin
        ld_resp_valid       = 1'b0;
        ld_resp_data        = '0;
        ctl_raddr_valid     = 1'b0;
        ctl_raddr           = '0;
        ctl_waddr_valid     = 1'b0;
        ctl_waddr           = '0;
        ctl_wdata           = '0;
        ctl_wmask           = '0;
        ctl_sent_repair     = 1'b0;
        ctl_repair_resolved = 1'b0;
        mem_req_valid       = 1'b0;
        mem_req_addr        = '0;
        if (!rst) begin
            ld_resp_valid = ctl_rdata_valid;
            ld_resp_data  = ctl_rdata_valid ? ctl_rdata : '0;
            case (state_q)
                S_IDLE: begin
                    if (ld_fire) begin
                        ctl_raddr_valid = 1'b1;
                        ctl_raddr       = ld_addr;
                    end
                    if (st_fire) begin
                        ctl_waddr_valid = 1'b1;
                        ctl_waddr       = st_addr;
                        ctl_wdata       = {32{st_data}};
                        ctl_wmask       = {124'd0, st_bmask} << {st_addr[6:2], 2'b00};
                    end
                end
                S_MEM_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = blk_addr_q;
                end
                S_FILL: begin
                    ctl_sent_repair = 1'b1;
                    ctl_waddr_valid = 1'b1;
                    ctl_waddr       = blk_addr_q;
                    ctl_wdata       = blk_data_q;
                    ctl_wmask       = '1;
                end
                S_RESOLVE: begin
                    ctl_repair_resolved = 1'b1;
                end
                S_REPLAY: begin
                    ctl_raddr_valid = 1'b1;
                    ctl_raddr       = ld_addr_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed testbench for dcache_arbiter. Build with +define+DCACHE_ARB_PERF_EN
// to also check the miss counters.
module tb_dcache_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req_valid;
    logic          ld_req_ready;
    logic [31:0]   ld_addr;
    logic          ld_resp_valid;
    logic [31:0]   ld_resp_data;
    logic          st_req_valid;
    logic          st_req_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [3:0]    st_bmask;
    logic          ctl_raddr_valid;
    logic [31:0]   ctl_raddr;
    logic          ctl_rdata_valid;
    logic [31:0]   ctl_rdata;
    logic          ctl_waddr_valid;
    logic [31:0]   ctl_waddr;
    logic [1023:0] ctl_wdata;
    logic [127:0]  ctl_wmask;
    logic          ctl_read_repair_request;
    logic          ctl_write_miss_repair;
    logic          ctl_sent_repair;
    logic          ctl_repair_resolved;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic          mem_resp_valid;
    logic [1023:0] mem_resp_data;
`ifdef DCACHE_ARB_PERF_EN
    logic [31:0]   perf_ld_miss_cnt;
    logic [31:0]   perf_st_miss_cnt;
    logic [31:0]   ld_cnt0;
    logic [31:0]   st_cnt0;
`endif

    int checks = 0;
    int errors = 0;
    logic [1023:0] blk1;
    logic [1023:0] blk2;
    logic [127:0]  mask_exp;

    always #5 clk = ~clk;

    dcache_arbiter dut (
        .clk                     (clk),
        .rst                     (rst),
        .ld_req_valid            (ld_req_valid),
        .ld_req_ready            (ld_req_ready),
        .ld_addr                 (ld_addr),
        .ld_resp_valid           (ld_resp_valid),
        .ld_resp_data            (ld_resp_data),
        .st_req_valid            (st_req_valid),
        .st_req_ready            (st_req_ready),
        .st_addr                 (st_addr),
        .st_data                 (st_data),
        .st_bmask                (st_bmask),
        .ctl_raddr_valid         (ctl_raddr_valid),
        .ctl_raddr               (ctl_raddr),
        .ctl_rdata_valid         (ctl_rdata_valid),
        .ctl_rdata               (ctl_rdata),
        .ctl_waddr_valid         (ctl_waddr_valid),
        .ctl_waddr               (ctl_waddr),
        .ctl_wdata               (ctl_wdata),
        .ctl_wmask               (ctl_wmask),
        .ctl_read_repair_request (ctl_read_repair_request),
        .ctl_write_miss_repair   (ctl_write_miss_repair),
        .ctl_sent_repair         (ctl_sent_repair),
        .ctl_repair_resolved     (ctl_repair_resolved),
        .mem_req_valid           (mem_req_valid),
        .mem_req_ready           (mem_req_ready),
        .mem_req_addr            (mem_req_addr),
        .mem_resp_valid          (mem_resp_valid),
        .mem_resp_data           (mem_resp_data)
`ifdef DCACHE_ARB_PERF_EN
        ,
        .perf_ld_miss_cnt        (perf_ld_miss_cnt),
        .perf_st_miss_cnt        (perf_st_miss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ld_req_valid = 1'b0; ld_addr = '0;
        st_req_valid = 1'b0; st_addr = '0; st_data = '0; st_bmask = '0;
        ctl_rdata_valid = 1'b0; ctl_rdata = '0;
        ctl_read_repair_request = 1'b0; ctl_write_miss_repair = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        for (int i = 0; i < 32; i++) begin
            blk1[i*32 +: 32] = 32'h1000_0000 + i;
            blk2[i*32 +: 32] = 32'h2000_0000 + (i * 3);
        end

        // Reset: all outputs low even with a read-data pulse present.
        repeat (2) tick();
        ctl_rdata_valid = 1'b1; ctl_rdata = 32'h1234_5678;
        #1;
        check("rst_ld_ready", ld_req_ready, 0);
        check("rst_st_ready", st_req_ready, 0);
        check("rst_resp_valid", ld_resp_valid, 0);
        check("rst_resp_data", ld_resp_data, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        ctl_rdata_valid = 1'b0; ctl_rdata = '0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ld_ready", ld_req_ready, 1);
        check("post_rst_st_ready", st_req_ready, 1);
        $display("reset released, both readies high");

        // Load hit to 0x1004.
        ld_req_valid = 1'b1; ld_addr = 32'h0000_1004;
        #1;
        check("hit_ld_ready", ld_req_ready, 1);
        check("hit_raddr_valid", ctl_raddr_valid, 1);
        check("hit_raddr", ctl_raddr, 32'h0000_1004);
        tick();
        ld_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("hit_busy_T%0d", k), ld_req_ready, 0);
            check($sformatf("hit_no_reissue_T%0d", k), ctl_raddr_valid, 0);
            tick();
        end
        ctl_rdata_valid = 1'b1; ctl_rdata = 32'hCAFE_0001;
        #1;
        check("hit_resp_valid", ld_resp_valid, 1);
        check("hit_resp_data", ld_resp_data, 32'hCAFE_0001);
        check("hit_busy_T4", ld_req_ready, 0);
        tick();
        ctl_rdata_valid = 1'b0; ctl_rdata = '0;
        #1;
        check("hit_ready_again", ld_req_ready, 1);
        $display("load hit 0x00001004 -> data cafe0001");

        // Store 0x2008, DEADBEEF, mask 0x3.
        st_req_valid = 1'b1; st_addr = 32'h0000_2008; st_data = 32'hDEAD_BEEF; st_bmask = 4'h3;
        #1;
        mask_exp = 128'h3 << 8;
        check("st_ready", st_req_ready, 1);
        check("st_waddr_valid", ctl_waddr_valid, 1);
        check("st_waddr", ctl_waddr, 32'h0000_2008);
        check("st_wmask", ctl_wmask, mask_exp);
        check("st_wdata_w2", ctl_wdata[95:64], 32'hDEAD_BEEF);
        check("st_wdata_w31", ctl_wdata[1023:992], 32'hDEAD_BEEF);
        check("st_no_raddr", ctl_raddr_valid, 0);
        tick();
        st_req_valid = 1'b0;
        #1;
        check("st_waddr_drop", ctl_waddr_valid, 0);
        $display("store 0x00002008 data deadbeef mask 3");

        // Same-block load and store: store wins, load follows next cycle.
        ld_req_valid = 1'b1; ld_addr = 32'h0000_3004;
        st_req_valid = 1'b1; st_addr = 32'h0000_3010; st_data = 32'h1122_3344; st_bmask = 4'hF;
        #1;
        check("sb_ld_ready", ld_req_ready, 0);
        check("sb_raddr_valid", ctl_raddr_valid, 0);
        check("sb_st_ready", st_req_ready, 1);
        check("sb_waddr_valid", ctl_waddr_valid, 1);
        check("sb_wmask", ctl_wmask, 128'h000F_0000);
        tick();
        st_req_valid = 1'b0;
        #1;
        check("sb_ld_ready_next", ld_req_ready, 1);
        check("sb_raddr_valid_next", ctl_raddr_valid, 1);
        check("sb_raddr_next", ctl_raddr, 32'h0000_3004);
        tick();
        ld_req_valid = 1'b0;
        repeat (3) tick();
        ctl_rdata_valid = 1'b1; ctl_rdata = 32'h0000_3333;
        tick();
        ctl_rdata_valid = 1'b0;
        $display("same-block load 0x00003004 / store 0x00003010: store first");

        // Different blocks issue together; the load then misses.
        ld_req_valid = 1'b1; ld_addr = 32'h0001_0044;
        st_req_valid = 1'b1; st_addr = 32'h0000_5004; st_data = 32'h5566_7788; st_bmask = 4'h1;
        #1;
        check("db_ld_ready", ld_req_ready, 1);
        check("db_raddr", ctl_raddr, 32'h0001_0044);
        check("db_waddr", ctl_waddr, 32'h0000_5004);
        check("db_wmask", ctl_wmask, 128'h10);
        tick();
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        repeat (3) tick();
        ctl_read_repair_request = 1'b1;
        tick();
        ctl_read_repair_request = 1'b0;
        #1;
        check("rm_mem_valid", mem_req_valid, 1);
        check("rm_mem_addr", mem_req_addr, 32'h0001_0000);
        check("rm_ld_ready", ld_req_ready, 0);
        check("rm_st_ready", st_req_ready, 0);
        tick();
        #1;
        check("rm_mem_addr_held", mem_req_addr, 32'h0001_0000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("rm_wait_no_req", mem_req_valid, 0);
        repeat (4) tick();
        check("rm_wait_no_fill", ctl_sent_repair, 0);
        mem_resp_valid = 1'b1; mem_resp_data = blk1;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        #1;
        check("rm_fill_sent", ctl_sent_repair, 1);
        check("rm_fill_wvalid", ctl_waddr_valid, 1);
        check("rm_fill_waddr", ctl_waddr, 32'h0001_0000);
        check("rm_fill_wmask", ctl_wmask, {128{1'b1}});
        check("rm_fill_wdata", ctl_wdata, blk1);
        tick();
        check("rm_resolved", ctl_repair_resolved, 1);
        check("rm_fill_once", ctl_sent_repair, 0);
        tick();
        check("rm_replay_valid", ctl_raddr_valid, 1);
        check("rm_replay_addr", ctl_raddr, 32'h0001_0044);
        check("rm_resolved_once", ctl_repair_resolved, 0);
        tick();
        check("rm_idle_busy", ld_req_ready, 0);
        check("rm_idle_st_ready", st_req_ready, 1);
        ctl_rdata_valid = 1'b1; ctl_rdata = 32'h0001_0044;
        tick();
        ctl_rdata_valid = 1'b0;
        #1;
        check("rm_ld_ready_after", ld_req_ready, 1);
        $display("read miss 0x00010044 -> fetch 0x00010000, fill, replay");

        // Simultaneous read and write miss: write block first, then replay.
`ifdef DCACHE_ARB_PERF_EN
        ld_cnt0 = perf_ld_miss_cnt;
        st_cnt0 = perf_st_miss_cnt;
`endif
        ld_req_valid = 1'b1; ld_addr = 32'h0000_7004;
        st_req_valid = 1'b1; st_addr = 32'h0000_6008; st_data = 32'h6666_6666; st_bmask = 4'hF;
        tick();
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        tick();
        ctl_read_repair_request = 1'b1; ctl_write_miss_repair = 1'b1;
        tick();
        ctl_read_repair_request = 1'b0; ctl_write_miss_repair = 1'b0;
        #1;
        check("dm_mem_addr", mem_req_addr, 32'h0000_6000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = blk2;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        #1;
        check("dm_fill_waddr", ctl_waddr, 32'h0000_6000);
        check("dm_fill_wdata", ctl_wdata, blk2);
        tick();
        check("dm_resolved", ctl_repair_resolved, 1);
        tick();
        check("dm_replay_valid", ctl_raddr_valid, 1);
        check("dm_replay_addr", ctl_raddr, 32'h0000_7004);
        tick();
`ifdef DCACHE_ARB_PERF_EN
        check("dm_perf_ld_delta", perf_ld_miss_cnt - ld_cnt0, 1);
        check("dm_perf_st_delta", perf_st_miss_cnt - st_cnt0, 1);
`endif
        ctl_rdata_valid = 1'b1; ctl_rdata = 32'h7777_0004;
        tick();
        ctl_rdata_valid = 1'b0;
        $display("dual miss: write block 0x00006000 filled, load 0x00007004 replayed");

        // Reset during MEM_WAIT abandons the fetch; late response ignored.
        st_req_valid = 1'b1; st_addr = 32'h0000_8000; st_data = 32'h8888_8888; st_bmask = 4'hF;
        tick();
        st_req_valid = 1'b0;
        tick();
        ctl_write_miss_repair = 1'b1;
        tick();
        ctl_write_miss_repair = 1'b0;
        #1;
        check("rw_mem_addr", mem_req_addr, 32'h0000_8000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rw_rst_st_ready", st_req_ready, 0);
        check("rw_rst_ld_ready", ld_req_ready, 0);
        tick();
        check("rw_after_edge_mem_valid", mem_req_valid, 0);
        check("rw_after_edge_fill", ctl_sent_repair, 0);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = blk1;
        #1;
        check("rw_ready_back_st", st_req_ready, 1);
        check("rw_ready_back_ld", ld_req_ready, 1);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("rw_late_resp_no_fill", ctl_sent_repair, 0);
        check("rw_late_resp_no_write", ctl_waddr_valid, 0);
        check("rw_still_idle", st_req_ready, 1);
`ifdef DCACHE_ARB_PERF_EN
        check("rw_perf_ld_cleared", perf_ld_miss_cnt, 0);
        check("rw_perf_st_cleared", perf_st_miss_cnt, 0);
`endif
        $display("reset in MEM_WAIT: fetch abandoned, late response ignored");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
